breath_seq_ctrl: RTL
====================

BREATH_SEQ_CTRL -- requirements
Module: breath_seq_ctrl

Interface
REQ-001 SHALL have parameter PWM_PERIOD, default 1000: clock cycles per PWM frame; also the maximum duty value.
REQ-002 SHALL have parameter STEP_FRAMES, default 50: PWM frames per duty step.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on the rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to begin breathing.
REQ-006 SHALL have port stop  input  1  one-cycle request to fade out and halt.
REQ-007 SHALL have port mode  input  2  pattern select: 00 ALL, 01 CHASE, 10 PINGPONG, 11 treated as ALL.
REQ-008 SHALL have port led  output  4  registered PWM drive, one bit per LED.
REQ-009 SHALL have port busy  output  1  registered; high whenever state is not IDLE.
REQ-010 SHALL have port breath_done  output  1  one-cycle pulse at the end of each full breath.
REQ-011 SHALL have port active_idx  output  2  index of the LED currently breathing (CHASE/PINGPONG).

Function
REQ-012 SHALL implement FSM states IDLE, RISE and FALL.
REQ-013 SHALL keep frame counter fcnt (0..PWM_PERIOD-1), step counter scnt (0..STEP_FRAMES-1) and duty (0..PWM_PERIOD), each sized by $clog2 of its range.
REQ-014 SHALL, in IDLE, on start=1 with stop=0: latch mode; at the next edge enter RISE with fcnt=0, scnt=0, duty=0, active_idx=0 and busy=1.
REQ-015 SHALL ignore start while busy=1; mode changes while busy have no effect.
REQ-016 SHALL, in IDLE with start=1 and stop=1 in the same cycle, remain in IDLE (stop wins).
REQ-017 SHALL advance fcnt every cycle in RISE/FALL and wrap PWM_PERIOD-1 to 0; scnt SHALL advance on each fcnt wrap and wrap STEP_FRAMES-1 to 0. The edge where both wrap is the step boundary.
REQ-018 SHALL, at each step boundary in RISE, increment duty; when duty becomes PWM_PERIOD, state SHALL become FALL at the same edge.
REQ-019 SHALL, at each step boundary in FALL, decrement duty; at the edge where duty becomes 0, breath_done SHALL be 1 for exactly the following cycle.
REQ-020 SHALL, when a breath completes with no stop pending, re-enter RISE, update active_idx, and continue without gap.
REQ-021 SHALL update active_idx per mode: ALL holds 0; CHASE follows 0,1,2,3,0,...; PINGPONG follows 0,1,2,3,2,1,0,1,...
REQ-022 SHALL register led at each edge in RISE/FALL from pre-edge values: led[i] <= sel[i] & (fcnt < duty), where sel = 4'b1111 in ALL and one-hot(active_idx) otherwise.
REQ-023 SHALL force led to 0 in IDLE.
REQ-024 SHALL latch stop in RISE/FALL into stop_pend.
REQ-025 SHALL, at the next step boundary in RISE with stop_pend set, enter FALL and decrement duty instead of incrementing. If duty is 0, it SHALL instead go to IDLE and pulse breath_done.
REQ-026 SHALL, when duty reaches 0 in FALL with stop_pend set, go to IDLE, clear stop_pend and pulse breath_done. busy SHALL be 0 from the following cycle.
REQ-027 SHALL give one full breath a length of 2*PWM_PERIOD*PWM_PERIOD*STEP_FRAMES cycles.

Reset
REQ-028 SHALL, while rst=1 at an edge, set state IDLE, led=0, busy=0, breath_done=0, active_idx=0, fcnt=scnt=duty=0, stop_pend=0.
REQ-029 SHALL let reset override any in-progress breath, start or stop in the same cycle.

Verification (PWM_PERIOD=8, STEP_FRAMES=1)
REQ-030 SHALL cover reset: rst=1 for 3 cycles -> led=0000, busy=0, breath_done=0, active_idx=0.
REQ-031 SHALL cover ALL mode: start pulse -> busy=1 next cycle; led high-time per frame follows 0,1..8,7..1; all four led bits identical; breath_done pulses 128 cycles after RISE entry and repeats every 128 cycles.
REQ-032 SHALL cover CHASE: start with mode=01 -> active_idx 0,1,2,3,0 across 5 breaths; only led[active_idx] ever toggles.
REQ-033 SHALL cover PINGPONG: start with mode=10 -> active_idx sequence 0,1,2,3,2,1,0,1 over 8 breaths.
REQ-034 SHALL cover stop: stop during RISE at duty=5 -> next boundary duty=4 in FALL, then 3..0; breath_done pulse; busy=0; a start asserted mid-fade is ignored.
REQ-035 SHALL cover mid-operation reset: rst=1 mid-FALL with led active -> all outputs 0 after that edge; a new start afterwards begins from duty 0 with active_idx=0.

Source files
------------

// File: rtl/breath_seq_ctrl_if.sv
// Breathing-LED controller bus: control requests in, PWM drive and status out.
// Latency: wires only; all timing is defined by the controller.
// Backpressure: none. start/stop are single-cycle requests, outputs are status.
// Ports: start, stop, mode (requester -> controller);
//        led, busy, breath_done, active_idx (controller -> requester).
interface breath_seq_ctrl_if;
  logic       start;
  logic       stop;
  logic [1:0] mode;
  logic [3:0] led;
  logic       busy;
  logic       breath_done;
  logic [1:0] active_idx;

  modport master (
    output start, stop, mode,
    input  led, busy, breath_done, active_idx
  );

  modport slave (
    input  start, stop, mode,
    output led, busy, breath_done, active_idx
  );
endinterface

// File: rtl/breath_seq_ctrl.sv
// Four-LED breathing sequencer: PWM duty ramps 0..PWM_PERIOD..0 per breath.
// Latency: start -> busy one edge; led registered one cycle behind fcnt/duty.
// Backpressure: none; start ignored while busy, stop fades out at the next step.
// Ports: clk, rst (sync, active-high); bus.start/stop/mode requests;
//        bus.led PWM drive, bus.busy, bus.breath_done pulse, bus.active_idx.
module breath_seq_ctrl #(
  parameter int PWM_PERIOD  = 1000,
  parameter int STEP_FRAMES = 50
) (
  input  logic              clk,
  input  logic              rst,
  breath_seq_ctrl_if.slave  bus
);

  localparam int FW = (PWM_PERIOD  > 1) ? $clog2(PWM_PERIOD)  : 1;
  localparam int SW = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
  localparam int DW = $clog2(PWM_PERIOD + 1);

  localparam logic [FW-1:0] FMAX = FW'(PWM_PERIOD - 1);
  localparam logic [SW-1:0] SMAX = SW'(STEP_FRAMES - 1);
  localparam logic [DW-1:0] DTOP = DW'(PWM_PERIOD - 1);

  localparam logic [1:0] MODE_CHASE = 2'b01;
  localparam logic [1:0] MODE_PING  = 2'b10;

  typedef enum logic [1:0] {IDLE, RISE, FALL} state_t;

  state_t        state, state_n;
  logic [FW-1:0] fcnt, fcnt_n;
  logic [SW-1:0] scnt, scnt_n;
  logic [DW-1:0] duty, duty_n;
  logic [1:0]    idx, idx_n;
  logic          dir, dir_n;       // pingpong direction: 0 counts up, 1 down
  logic [1:0]    mode_q, mode_n;
  logic          stop_pend, stop_n;
  logic          done_q, done_n;
  logic          busy_q, busy_n;
  logic [3:0]    led_q, led_n;
  logic [3:0]    sel;
  logic          fwrap, boundary;

  always_comb begin
    state_n  = state;
    fcnt_n   = fcnt;
    scnt_n   = scnt;
    duty_n   = duty;
    idx_n    = idx;
    dir_n    = dir;
    mode_n   = mode_q;
    stop_n   = stop_pend;
    done_n   = 1'b0;
    led_n    = 4'b0000;
    sel      = (mode_q == MODE_CHASE || mode_q == MODE_PING) ? (4'b0001 << idx) : 4'b1111;
    fwrap    = (fcnt == FMAX);
    boundary = fwrap && (scnt == SMAX);

    case (state)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          state_n = RISE;
          fcnt_n  = '0;
          scnt_n  = '0;
          duty_n  = '0;
          idx_n   = 2'd0;
          dir_n   = 1'b0;
          mode_n  = bus.mode;
        end
      end

      RISE, FALL: begin
        led_n  = sel & {4{DW'(fcnt) < duty}};
        fcnt_n = fwrap ? '0 : fcnt + FW'(1);
        if (fwrap) scnt_n = (scnt == SMAX) ? '0 : scnt + SW'(1);
        if (bus.stop) stop_n = 1'b1;

        if (boundary) begin
          if (state == RISE && !stop_pend) begin
            duty_n = duty + DW'(1);
            if (duty == DTOP) state_n = FALL;
          end else if (duty == '0) begin
            // stop caught a rise that had not left zero yet
            state_n = IDLE;
            stop_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            // normal fall, or a rise turned around by a pending stop
            duty_n  = duty - DW'(1);
            state_n = FALL;
            if (duty == DW'(1)) begin
              done_n = 1'b1;
              if (stop_pend) begin
                state_n = IDLE;
                stop_n  = 1'b0;
              end else begin
                state_n = RISE;
                case (mode_q)
                  MODE_CHASE: idx_n = idx + 2'd1;
                  MODE_PING: begin
                    if (!dir) begin
                      if (idx == 2'd3) begin
                        idx_n = 2'd2;
                        dir_n = 1'b1;
                      end else begin
                        idx_n = idx + 2'd1;
                      end
                    end else begin
                      if (idx == 2'd0) begin
                        idx_n = 2'd1;
                        dir_n = 1'b0;
                      end else begin
                        idx_n = idx - 2'd1;
                      end
                    end
                  end
                  default: idx_n = 2'd0;
                endcase
              end
            end
          end
        end
      end

      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      fcnt      <= '0;
      scnt      <= '0;
      duty      <= '0;
      idx       <= 2'd0;
      dir       <= 1'b0;
      mode_q    <= 2'b00;
      stop_pend <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      led_q     <= 4'b0000;
    end else begin
      state     <= state_n;
      fcnt      <= fcnt_n;
      scnt      <= scnt_n;
      duty      <= duty_n;
      idx       <= idx_n;
      dir       <= dir_n;
      mode_q    <= mode_n;
      stop_pend <= stop_n;
      done_q    <= done_n;
      busy_q    <= busy_n;
      led_q     <= led_n;
    end
  end

  assign bus.led         = led_q;
  assign bus.busy        = busy_q;
  assign bus.breath_done = done_q;
  assign bus.active_idx  = idx;

endmodule
